sifive_tl_echo_responder: RTL and testbench
===========================================

SIFIVE_TL_ECHO_RESPONDER -- requirements
Module: sifive_tl_echo_responder

Interface
REQ-001 Parameter DATA_W, 32, data width in bits; fixed at 32.
REQ-002 Parameter ADDR_W, 8, byte-address width.
REQ-003 Parameter SOURCE_W, 4, width of the A/D source ID.
REQ-004 Parameter ECHO_W, 2, width of the echo field carried from A to D.
REQ-005 Parameter DEPTH, 4, number of response FIFO entries; power of two, at least 2.
REQ-006 clock  input  1  single clock; all state is rising-edge.
REQ-007 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-008 a_valid  input  1  A-channel request valid.
REQ-009 a_ready  output  1  A-channel accept.
REQ-010 a_opcode  input  3  A-channel opcode.
REQ-011 a_size  input  3  log2 of the byte count.
REQ-012 a_source  input  SOURCE_W  requester ID.
REQ-013 a_address  input  ADDR_W  byte address.
REQ-014 a_mask  input  4  byte lanes.
REQ-015 a_data  input  DATA_W  write data.
REQ-016 a_echo  input  ECHO_W  echo field, returned unchanged on D.
REQ-017 d_valid  output  1  D-channel response valid.
REQ-018 d_ready  input  1  D-channel accept.
REQ-019 d_opcode, d_size, d_source, d_echo, d_data, d_denied, d_corrupt  outputs  3, 3, SOURCE_W, ECHO_W, DATA_W, 1, 1  D-channel response fields.

Function
REQ-020 Backing store SHALL be 16 words of 32 bits, indexed by a_address[5:2].
REQ-021 a_ready SHALL equal FIFO-not-full, with no dependence on d_ready.
REQ-022 An A fire (a_valid and a_ready) SHALL push one entry holding {d_opcode, a_size, a_source, a_echo, data, denied}.
REQ-023 A fire of Get (4) SHALL capture the store word at index, in the fire cycle, into the entry; response opcode is AccessAckData (1).
REQ-024 A fire of PutFullData (0) or PutPartialData (1) SHALL write the a_data bytes enabled by a_mask at the clock edge ending the fire cycle.
REQ-025 A Put response SHALL be AccessAck (0) with d_data = 0.
REQ-026 A Get following a Put to the same word SHALL return the post-write value.
REQ-027 d_valid SHALL equal FIFO-not-empty; d_* SHALL present the head entry.
REQ-028 A D fire (d_valid and d_ready) SHALL pop the head entry.
REQ-029 Minimum latency: d_valid SHALL rise in the cycle after the A fire, with no combinational A-to-D path.
REQ-030 Responses SHALL issue in strict acceptance order.
REQ-031 Push and pop in the same cycle SHALL leave the occupancy count unchanged.
REQ-032 When full, a_ready SHALL be 0 even if a pop occurs that cycle.
REQ-033 FIFO read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked in log2(DEPTH)+1 bits.
REQ-034 d_echo, d_source and d_size SHALL be bit-identical to the accepted a_echo, a_source and a_size.
REQ-035 d_corrupt SHALL equal d_denied when d_opcode is AccessAckData, and 0 otherwise.
REQ-036 While d_valid is 1 and d_ready is 0, all d_* outputs SHALL be held stable.

Reset
REQ-037 Asserting reset_n low SHALL immediately empty the FIFO, drive d_valid = 0 and drive a_ready = 1 after deassertion.
REQ-038 Reset SHALL clear all store words to 0.
REQ-039 Entries in flight when reset asserts SHALL be discarded, and no D response for them SHALL ever issue.

Configuration
REQ-040 With macro SIFIVE_TL_ECHO_RESP_ERR_EN defined, a request SHALL get denied = 1 and leave the store unmodified if any of the following holds: a_address >= 64; a_size > 2; opcode not in {0, 1, 4}.
REQ-041 A denied illegal opcode SHALL respond AccessAck; a denied Get SHALL respond AccessAckData with d_data = 0.
REQ-042 Without the macro, d_denied and d_corrupt SHALL be tied 0, the index SHALL wrap on a_address[5:2], and illegal opcodes SHALL get AccessAck with no effect.

Structure
REQ-043 Package sifive_tl_echo_pkg SHALL hold the TL opcode localparams (Get, PutFull, PutPartial, AccessAck, AccessAckData) and the FIFO entry struct typedef.
REQ-044 The FIFO SHALL be sub-module sifive_tl_echo_fifo (parameterised width and depth, async active-low reset); store and decode logic SHALL live in the top.

Verification
REQ-045 PutFull addr 0x08, data 0xDEADBEEF, mask 0xF, source 3, echo 2 -> next cycle D AccessAck, source 3, echo 2, size 2, denied 0.
REQ-046 Get addr 0x08, issued in the cycle after that Put -> AccessAckData with d_data 0xDEADBEEF and echo returned unchanged.
REQ-047 PutPartial mask 0x3, data 0x00001234 onto 0xDEADBEEF, then Get -> d_data 0xDEAD1234.
REQ-048 d_ready held 0 while 5 Gets are offered -> exactly 4 accepted and a_ready 0; release d_ready -> 4 responses in order, then the 5th is accepted.
REQ-049 Simultaneous push and pop at occupancy 2 for 10 cycles -> occupancy stays 2 and no response is lost or duplicated.
REQ-050 With ERR_EN defined, Get addr 0x80 -> denied 1, corrupt 1, data 0; reset_n pulsed low with 3 entries queued -> d_valid 0 immediately and no stale responses afterwards.

Source files
------------

// File: rtl/sifive_tl_echo_pkg.sv
// Shared TileLink opcodes and the response FIFO entry layout for the echo responder.
package sifive_tl_echo_pkg;

    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    localparam int TL_DATA_W   = 32;
    localparam int TL_SOURCE_W = 4;
    localparam int TL_ECHO_W   = 2;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [2:0]             size;
        logic [TL_SOURCE_W-1:0] source;
        logic [TL_ECHO_W-1:0]   echo;
        logic [TL_DATA_W-1:0]   data;
        logic                   denied;
    } tl_d_entry_t;

    localparam int TL_ENTRY_W = $bits(tl_d_entry_t);

endpackage

// File: rtl/sifive_tl_echo_fifo.sv
// Response FIFO: power-of-two depth, wrapping pointers, occupancy counter one bit wider.
module sifive_tl_echo_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en, pop_en;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_en && !pop_en)      count_d = count_q + CNT_ONE;
        else if (pop_en && !push_en) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/sifive_tl_echo_responder.sv
// TileLink-style echo responder: 16-word store, queued D responses in acceptance order.
// Define SIFIVE_TL_ECHO_RESP_ERR_EN to deny out-of-range, oversize and unknown requests.
module sifive_tl_echo_responder
    import sifive_tl_echo_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int SOURCE_W = 4,
    parameter int ECHO_W   = 2,
    parameter int DEPTH    = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [3:0]          a_mask,
    input  logic [DATA_W-1:0]   a_data,
    input  logic [ECHO_W-1:0]   a_echo,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [2:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic [ECHO_W-1:0]   d_echo,
    output logic [DATA_W-1:0]   d_data,
    output logic                d_denied,
    output logic                d_corrupt
);
    logic [DATA_W-1:0] store_q [16];
    logic [DATA_W-1:0] store_d [16];
    logic [3:0]        idx;
    logic              is_get, is_put, denied, fifo_full, fifo_empty;
    tl_d_entry_t       entry, head;
    logic              unused_addr_bits;

    assign idx    = a_address[5:2];
    assign is_get = (a_opcode == TL_GET);
    assign is_put = (a_opcode == TL_PUT_FULL) || (a_opcode == TL_PUT_PARTIAL);
    assign unused_addr_bits = ^{a_address[1:0], a_address[ADDR_W-1:6]};

`ifdef SIFIVE_TL_ECHO_RESP_ERR_EN
    assign denied = (a_address >= ADDR_W'(64)) || (a_size > 3'd2) || !(is_get || is_put);
`else
    assign denied = 1'b0;
`endif

    // The Get reads the registered store, so a Put in the previous cycle is already visible.
    always_comb begin
        entry        = '0;
        entry.opcode = is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
        entry.size   = a_size;
        entry.source = a_source;
        entry.echo   = a_echo;
        entry.data   = (is_get && !denied) ? store_q[idx] : '0;
        entry.denied = denied;
    end

    always_comb begin
        store_d = store_q;
        if (a_valid && a_ready && is_put && !denied) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) store_d[idx][8*b +: 8] = a_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) store_q[i] <= '0;
        end else begin
            store_q <= store_d;
        end
    end

    sifive_tl_echo_fifo #(
        .WIDTH (TL_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (a_valid),
        .push_data (entry),
        .full      (fifo_full),
        .pop       (d_ready),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign a_ready  = !fifo_full;
    assign d_valid  = !fifo_empty;
    assign d_opcode = head.opcode;
    assign d_size   = head.size;
    assign d_source = head.source;
    assign d_echo   = head.echo;
    assign d_data   = head.data;

`ifdef SIFIVE_TL_ECHO_RESP_ERR_EN
    assign d_denied  = head.denied;
    assign d_corrupt = (head.opcode == TL_ACCESS_ACK_DATA) ? head.denied : 1'b0;
`else
    logic unused_head_denied;
    assign unused_head_denied = head.denied;
    assign d_denied  = 1'b0;
    assign d_corrupt = 1'b0;
`endif

endmodule

// File: tb/tb_sifive_tl_echo_responder.sv
// Bench for sifive_tl_echo_responder: directed table, full/concurrent/reset corners, random traffic.
module tb_sifive_tl_echo_responder;
    localparam int RW = 46;
    localparam int DEPTH = 4;
`ifdef SIFIVE_TL_ECHO_RESP_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0, a_ready;
    logic [2:0]  a_opcode = '0, a_size = 3'd2;
    logic [3:0]  a_source = '0;
    logic [7:0]  a_address = '0;
    logic [3:0]  a_mask = '0;
    logic [31:0] a_data = '0;
    logic [1:0]  a_echo = '0;
    logic        d_valid, d_ready = 1'b0;
    logic [2:0]  d_opcode, d_size;
    logic [3:0]  d_source;
    logic [1:0]  d_echo;
    logic [31:0] d_data;
    logic        d_denied, d_corrupt;

    int total = 0;
    int bad = 0;
    logic [RW-1:0] exp_q[$];
    logic [31:0]   m_mem [16];
    bit            last_push, last_pop;

    sifive_tl_echo_responder dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .a_echo(a_echo), .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_size(d_size), .d_source(d_source), .d_echo(d_echo), .d_data(d_data),
        .d_denied(d_denied), .d_corrupt(d_corrupt)
    );

    always #5 clock = ~clock;

    function automatic logic [RW-1:0] pack(input logic [2:0] op, input logic [2:0] sz,
                                           input logic [3:0] src, input logic [1:0] ec,
                                           input logic [31:0] dat, input logic den,
                                           input logic cor);
        return {op, sz, src, ec, dat, den, cor};
    endfunction

    function automatic logic [RW-1:0] dut_pack();
        return {d_opcode, d_size, d_source, d_echo, d_data, d_denied, d_corrupt};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the response a request should produce and its effect on the word store.
    task automatic model_accept();
        logic        den;
        logic [3:0]  w;
        logic [31:0] rd;
        logic        legal;
        legal = (a_opcode == 3'd0) || (a_opcode == 3'd1) || (a_opcode == 3'd4);
        den = ERR && ((a_address >= 8'd64) || (a_size > 3'd2) || !legal);
        w = a_address[5:2];
        if (a_opcode == 3'd4) begin
            rd = den ? 32'h0 : m_mem[w];
            exp_q.push_back(pack(3'd1, a_size, a_source, a_echo, rd, den, den));
        end else begin
            exp_q.push_back(pack(3'd0, a_size, a_source, a_echo, 32'h0, den, 1'b0));
            if ((a_opcode == 3'd0 || a_opcode == 3'd1) && !den)
                for (int b = 0; b < 4; b++)
                    if (a_mask[b]) m_mem[w][8*b +: 8] = a_data[8*b +: 8];
        end
    endtask

    // Checks the current outputs against the model, advances the model, then one clock.
    task automatic tick();
        check("a_ready", 64'(a_ready), 64'(exp_q.size() < DEPTH));
        check("d_valid", 64'(d_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("d_head", 64'(dut_pack()), 64'(exp_q[0]));
        last_pop  = (exp_q.size() > 0) && d_ready;
        last_push = a_valid && (exp_q.size() < DEPTH);
        if (last_pop) void'(exp_q.pop_front());
        if (last_push) model_accept();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [7:0] addr, input logic [31:0] dat,
                           input logic [3:0] msk, input logic [2:0] sz, input logic [3:0] src,
                           input logic [1:0] ec);
        a_valid = 1'b1; a_opcode = op; a_address = addr; a_data = dat;
        a_mask = msk; a_size = sz; a_source = src; a_echo = ec;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [2:0]  size;
        logic [3:0]  src;
        logic [1:0]  echo;
        logic [2:0]  e_op;
        logic [31:0] e_data;
        logic        e_den;
        logic        e_cor;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int n_acc;
        int n_resp;

        vecs[0]  = '{3'd0, 8'h08, 32'hDEADBEEF, 4'hF, 3'd2, 4'd3, 2'd2, 3'd0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{3'd4, 8'h08, 32'h0, 4'hF, 3'd2, 4'd5, 2'd1, 3'd1, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 8'h08, 32'h00001234, 4'h3, 3'd2, 4'd1, 2'd3, 3'd0, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{3'd4, 8'h08, 32'h0, 4'hF, 3'd2, 4'd2, 2'd0, 3'd1, 32'hDEAD1234, 1'b0, 1'b0};
        vecs[4]  = '{3'd4, 8'h0C, 32'h0, 4'hF, 3'd2, 4'd7, 2'd1, 3'd1, 32'h0, 1'b0, 1'b0};
        vecs[5]  = '{3'd2, 8'h0C, 32'h5, 4'hF, 3'd2, 4'd8, 2'd2, 3'd0, 32'h0, ERR, 1'b0};
        vecs[6]  = '{3'd4, 8'h0C, 32'h0, 4'hF, 3'd2, 4'd9, 2'd3, 3'd1, 32'h0, 1'b0, 1'b0};
        vecs[7]  = '{3'd0, 8'h48, 32'h11112222, 4'hF, 3'd2, 4'd10, 2'd0, 3'd0, 32'h0, ERR, 1'b0};
        vecs[8]  = '{3'd4, 8'h08, 32'h0, 4'hF, 3'd2, 4'd11, 2'd1,
                     3'd1, (ERR ? 32'hDEAD1234 : 32'h11112222), 1'b0, 1'b0};
        vecs[9]  = '{3'd4, 8'h80, 32'h0, 4'hF, 3'd2, 4'd12, 2'd2, 3'd1, 32'h0, ERR, ERR};
        vecs[10] = '{3'd4, 8'h08, 32'h0, 4'hF, 3'd3, 4'd13, 2'd3,
                     3'd1, (ERR ? 32'h0 : 32'h11112222), ERR, ERR};

        for (int i = 0; i < 16; i++) m_mem[i] = '0;

        // Reset
        repeat (3) @(posedge clock);
        #1;
        check("reset_d_valid", 64'(d_valid), 64'(0));
        check("reset_a_ready", 64'(a_ready), 64'(1));
        reset_n = 1'b1;

        // Directed table, issued back to back with d_ready high
        d_ready = 1'b1;
        for (int i = 0; i <= 11; i++) begin
            if (i > 0) begin
                check("vec_d_valid", 64'(d_valid), 64'(1));
                check($sformatf("vec%0d_resp", i - 1), 64'(dut_pack()),
                      64'(pack(vecs[i-1].e_op, vecs[i-1].size, vecs[i-1].src, vecs[i-1].echo,
                               vecs[i-1].e_data, vecs[i-1].e_den, vecs[i-1].e_cor)));
            end
            if (i < 11) drive_a(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask,
                                vecs[i].size, vecs[i].src, vecs[i].echo);
            else a_valid = 1'b0;
            tick();
        end
        repeat (2) tick();

        // Backpressure: five Gets offered with d_ready low, only four fit
        d_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 5; c++) begin
            drive_a(3'd4, 8'h08, 32'h0, 4'hF, 3'd2, 4'(n_acc), 2'(n_acc));
            tick();
            if (last_push) n_acc++;
        end
        check("full_accept_count", 64'(n_acc), 64'(4));
        check("full_a_ready", 64'(a_ready), 64'(0));
        d_ready = 1'b1;
        check("full_pop_a_ready", 64'(a_ready), 64'(0));
        tick();
        for (int c = 0; c < 4 && n_acc < 5; c++) begin
            tick();
            if (last_push) n_acc++;
        end
        check("fifth_accepted", 64'(n_acc), 64'(5));
        a_valid = 1'b0;
        repeat (6) tick();

        // Steady push+pop at occupancy two
        d_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive_a(3'd4, 8'h0C, 32'h0, 4'hF, 3'd2, 4'(c), 2'(c));
            tick();
        end
        d_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive_a(3'd0, 8'h10, $urandom, 4'hF, 3'd2, 4'(c + 2), 2'(c));
            tick();
        end
        a_valid = 1'b0;
        n_resp = 0;
        for (int c = 0; c < 5; c++) begin
            if (d_valid) n_resp++;
            tick();
        end
        check("steady_occupancy", 64'(n_resp), 64'(2));

        // Reset with three entries queued
        d_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_a(3'd4, 8'h08, 32'h0, 4'hF, 3'd2, 4'(c + 4), 2'(c));
            tick();
        end
        a_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_d_valid", 64'(d_valid), 64'(0));
        exp_q.delete();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        d_ready = 1'b1;
        check("postrst_a_ready", 64'(a_ready), 64'(1));
        repeat (4) tick();
        drive_a(3'd4, 8'h08, 32'h0, 4'hF, 3'd2, 4'd6, 2'd1);
        tick();
        a_valid = 1'b0;
        check("postrst_get", 64'(dut_pack()),
              64'(pack(3'd1, 3'd2, 4'd6, 2'd1, 32'h0, 1'b0, 1'b0)));
        tick();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            int r;
            logic [2:0] op;
            r = $urandom_range(0, 9);
            op = (r < 4) ? 3'd4 : (r < 6) ? 3'd0 : (r < 8) ? 3'd1 : 3'($urandom_range(0, 7));
            drive_a(op,
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 63)),
                    $urandom, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2,
                    4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            a_valid = ($urandom_range(0, 2) != 0);
            d_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        a_valid = 1'b0;
        d_ready = 1'b1;
        repeat (8) tick();
        check("final_empty", 64'(d_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
